cwc_capture_ctrl: RTL and testbench

- Parametrised trigger and capture controller for the ChipWatcher logic analyser.
- Evaluates masked level/edge conditions over the probed bus nodes and counts trigger occurrences.
- Generates circular trace-RAM write strobes and addresses with programmable pre-trigger and post-trigger depth.
- Successor to the fixed single-bus capture path: node count, RAM depth, combine mode and occurrence count are all configurable.

---
 rtl/cwc_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cwc_capture_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwc_capture_ctrl.sv
// ChipWatcher trigger/capture controller: masked level/edge trigger with occurrence count,
// circular trace-RAM write generation. Optional storage qualification via CWC_STORAGE_QUAL_EN.
module cwc_capture_ctrl #(
    parameter int NODE_NUM = 4,
    parameter int DEPTH    = 5461,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic                trig_clk_i,
    input  logic                jrstn_i,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic [NODE_NUM-1:0] din_i,
    input  logic [NODE_NUM-1:0] trig_val_i,
    input  logic [NODE_NUM-1:0] trig_mask_i,
    input  logic [NODE_NUM-1:0] trig_edge_i,
    input  logic                trig_or_i,
    input  logic [CNT_W-1:0]    trig_cnt_i,
    input  logic [ADDR_W-1:0]   pre_len_i,
    input  logic [ADDR_W-1:0]   post_len_i,
`ifdef CWC_STORAGE_QUAL_EN
    input  logic                sq_en_i,
    input  logic [NODE_NUM-1:0] sq_mask_i,
`endif
    output logic                wt_ce_o,
    output logic                wt_en_o,
    output logic [ADDR_W-1:0]   wt_addr_o,
    output logic [NODE_NUM-1:0] wt_data_o,
    output logic                st_armed_o,
    output logic                st_trig_o,
    output logic                st_done_o,
    output logic [ADDR_W-1:0]   trig_addr_o
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, pre_cnt_q, post_cnt_q;
    logic [CNT_W-1:0]    occ_q;
    logic [NODE_NUM-1:0] din_hist_q;

    logic                wt_ce_q, wt_en_q, st_armed_q, st_trig_q, st_done_q;
    logic [ADDR_W-1:0]   wt_addr_q, trig_addr_q;
    logic [NODE_NUM-1:0] wt_data_q;

    logic [NODE_NUM-1:0] node_hit;
    logic                cond, qual, active, ce, wr, fire, start;
    logic                pre_last, post_last;
    logic [CNT_W-1:0]    occ_target;
    logic [ADDR_W-1:0]   post_eff, addr_inc;

`ifdef CWC_STORAGE_QUAL_EN
    assign qual = ~sq_en_i | (|(din_i & sq_mask_i));
`else
    assign qual = 1'b1;
`endif

    // An edge hit additionally needs the node to differ from its previous sample.
    assign node_hit   = (din_i ~^ trig_val_i) & (~trig_edge_i | (din_hist_q ^ din_i));
    assign occ_target = (trig_cnt_i == '0) ? CNT_W'(1) : trig_cnt_i;
    assign post_eff   = (post_len_i > ADDR_W'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : post_len_i;
    assign addr_inc   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign pre_last   = (pre_cnt_q + 1'b1) == pre_len_i;
    assign post_last  = (post_cnt_q + 1'b1) == post_eff;

    always_comb begin
        cond = 1'b1;
        if (trig_mask_i != '0) begin
            if (trig_or_i) cond = |(node_hit & trig_mask_i);
            else           cond = &(node_hit | ~trig_mask_i);
        end
    end

    always_comb begin
        state_d = state_q;
        active  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        ce      = active && !abort_i;
        start   = arm_i && !abort_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        fire    = (state_q == S_WAIT) && !abort_i && cond && ((occ_q + 1'b1) == occ_target);
        // The trigger sample is always stored so trig_addr points at real data.
        wr      = ce && (qual || fire);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort_i)    state_d = S_IDLE;
                else if (start) state_d = (pre_len_i == '0) ? S_WAIT : S_PRE;
            end
            S_PRE: begin
                if (abort_i)               state_d = S_IDLE;
                else if (wr && pre_last)   state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort_i)   state_d = S_IDLE;
                else if (fire) state_d = (post_eff == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (abort_i)               state_d = S_IDLE;
                else if (wr && post_last)  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge trig_clk_i or negedge jrstn_i) begin
        if (!jrstn_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge trig_clk_i or negedge jrstn_i) begin
        if (!jrstn_i) begin
            addr_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            occ_q       <= '0;
            din_hist_q  <= '0;
            wt_ce_q     <= 1'b0;
            wt_en_q     <= 1'b0;
            wt_addr_q   <= '0;
            wt_data_q   <= '0;
            st_armed_q  <= 1'b0;
            st_trig_q   <= 1'b0;
            st_done_q   <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            wt_ce_q    <= ce;
            wt_en_q    <= wr;
            wt_data_q  <= din_i;
            st_armed_q <= ce;
            st_done_q  <= (state_q == S_DONE) && (state_d == S_DONE);
            if (start) begin
                addr_q     <= '0;
                pre_cnt_q  <= '0;
                post_cnt_q <= '0;
                occ_q      <= '0;
                din_hist_q <= '0;
                st_trig_q  <= 1'b0;
            end else begin
                din_hist_q <= din_i;
                if (wr) begin
                    wt_addr_q <= addr_q;
                    addr_q    <= addr_inc;
                    if (state_q == S_PRE)  pre_cnt_q  <= pre_cnt_q + 1'b1;
                    if (state_q == S_POST) post_cnt_q <= post_cnt_q + 1'b1;
                end
                if ((state_q == S_WAIT) && cond && !abort_i) occ_q <= occ_q + 1'b1;
                if (fire) begin
                    st_trig_q   <= 1'b1;
                    trig_addr_q <= addr_q;
                end
            end
        end
    end

    assign wt_ce_o     = wt_ce_q;
    assign wt_en_o     = wt_en_q;
    assign wt_addr_o   = wt_addr_q;
    assign wt_data_o   = wt_data_q;
    assign st_armed_o  = st_armed_q;
    assign st_trig_o   = st_trig_q;
    assign st_done_o   = st_done_q;
    assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Directed self-checking bench for cwc_capture_ctrl with DEPTH=16.
module tb_cwc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        arm, abort, trigOr;
    logic [3:0]  din, trigVal, trigMask, trigEdge;
    logic [7:0]  trigCnt;
    logic [15:0] preLen, postLen;
    logic        wtCe, wtEn, stArmed, stTrig, stDone;
    logic [15:0] wtAddr, trigAddr;
    logic [3:0]  wtData;
`ifdef CWC_STORAGE_QUAL_EN
    logic        sqEn;
    logic [3:0]  sqMask;
`endif

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    cwc_capture_ctrl #(.NODE_NUM(4), .DEPTH(16), .ADDR_W(16), .CNT_W(8)) dut (
        .trig_clk_i (clk),
        .jrstn_i    (rstN),
        .arm_i      (arm),
        .abort_i    (abort),
        .din_i      (din),
        .trig_val_i (trigVal),
        .trig_mask_i(trigMask),
        .trig_edge_i(trigEdge),
        .trig_or_i  (trigOr),
        .trig_cnt_i (trigCnt),
        .pre_len_i  (preLen),
        .post_len_i (postLen),
`ifdef CWC_STORAGE_QUAL_EN
        .sq_en_i    (sqEn),
        .sq_mask_i  (sqMask),
`endif
        .wt_ce_o    (wtCe),
        .wt_en_o    (wtEn),
        .wt_addr_o  (wtAddr),
        .wt_data_o  (wtData),
        .st_armed_o (stArmed),
        .st_trig_o  (stTrig),
        .st_done_o  (stDone),
        .trig_addr_o(trigAddr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [3:0] mask, input logic [3:0] val, input logic [3:0] edg,
                             input logic orMode, input logic [7:0] cnt,
                             input logic [15:0] pre, input logic [15:0] post);
        trigMask = mask; trigVal = val; trigEdge = edg; trigOr = orMode;
        trigCnt = cnt; preLen = pre; postLen = post;
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nCompared++; if (wtCe !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_wt_ce got %b want 0", wtCe); end
        nCompared++; if (wtEn !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_wt_en got %b want 0", wtEn); end
        nCompared++; if (wtAddr !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_wt_addr got %0d want 0", wtAddr); end
        nCompared++; if (stDone !== 1'b0 || stTrig !== 1'b0 || stArmed !== 1'b0)
            begin nMismatched++; $display("[TB] FAIL reset_status got %b%b%b want 000", stArmed, stTrig, stDone); end
        @(posedge clk);
        #2 rstN = 1'b1;
    endtask

    task automatic test_basic();
        int nWrites = 0;
        configure(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'd1, 16'd4, 16'd3);
        din = 4'b0000;
        pulseArm();
        for (int s = 0; s <= 12; s++) begin
            din = (s == 9) ? 4'b0001 : 4'b0000;
            tick();
            nWrites += int'(wtEn);
            nCompared++; if (wtEn !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_wt_en s=%0d got %b want 1", s, wtEn); end
            nCompared++; if (wtAddr !== 16'(s)) begin nMismatched++; $display("[TB] FAIL basic_wt_addr got %0d want %0d", wtAddr, s); end
            nCompared++; if (wtData !== din) begin nMismatched++; $display("[TB] FAIL basic_wt_data got %h want %h", wtData, din); end
            if (s == 8) begin
                nCompared++; if (stTrig !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_early_trig got %b want 0", stTrig); end
            end
            if (s == 9) begin
                nCompared++; if (stTrig !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_st_trig got %b want 1", stTrig); end
                nCompared++; if (trigAddr !== 16'd9) begin nMismatched++; $display("[TB] FAIL basic_trig_addr got %0d want 9", trigAddr); end
            end
            if (s == 12) begin
                nCompared++; if (stDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_done_early got %b want 0", stDone); end
            end
        end
        din = 4'b0000;
        tick();
        nCompared++; if (stDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_st_done got %b want 1", stDone); end
        nCompared++; if (wtEn !== 1'b0 || wtCe !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_done_we got ce=%b en=%b want 0 0", wtCe, wtEn); end
        nCompared++; if (stArmed !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_armed got %b want 0", stArmed); end
        nCompared++; if (nWrites != 13) begin nMismatched++; $display("[TB] FAIL basic_write_count got %0d want 13", nWrites); end
    endtask

    task automatic test_wrap();
        configure(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'd1, 16'd2, 16'd3);
        din = 4'b0000;
        pulseArm();
        for (int s = 0; s <= 23; s++) begin
            din = (s == 20) ? 4'b0001 : 4'b0000;
            tick();
            nCompared++; if (wtEn !== 1'b1 || wtAddr !== 16'(s % 16))
                begin nMismatched++; $display("[TB] FAIL wrap_addr s=%0d got en=%b addr=%0d want 1 %0d", s, wtEn, wtAddr, s % 16); end
            if (s == 20) begin
                nCompared++; if (trigAddr !== 16'd4) begin nMismatched++; $display("[TB] FAIL wrap_trig_addr got %0d want 4", trigAddr); end
            end
        end
        tick();
        nCompared++; if (stDone !== 1'b1 || wtEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_done got done=%b en=%b want 1 0", stDone, wtEn); end
    endtask

    task automatic test_edge();
        logic [3:0] seq [13] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
        configure(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'd1, 16'd0, 16'd0);
        din = 4'b0010;
        pulseArm();
        tick();
        nCompared++; if (stTrig !== 1'b1 || trigAddr !== 16'd0)
            begin nMismatched++; $display("[TB] FAIL edge_first_sample got trig=%b addr=%0d want 1 0", stTrig, trigAddr); end
        tick();
        nCompared++; if (stDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL edge_first_done got %b want 1", stDone); end

        configure(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'd3, 16'd2, 16'd0);
        pulseArm();
        for (int s = 0; s <= 12; s++) begin
            din = seq[s];
            tick();
            nCompared++; if (wtAddr !== 16'(s)) begin nMismatched++; $display("[TB] FAIL edge_addr got %0d want %0d", wtAddr, s); end
            if (s == 5 || s == 11) begin
                nCompared++; if (stTrig !== 1'b0) begin nMismatched++; $display("[TB] FAIL edge_no_trig s=%0d got %b want 0", s, stTrig); end
            end
        end
        nCompared++; if (stTrig !== 1'b1 || trigAddr !== 16'd12)
            begin nMismatched++; $display("[TB] FAIL edge_third_rise got trig=%b addr=%0d want 1 12", stTrig, trigAddr); end
        tick();
        nCompared++; if (stDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL edge_done got %b want 1", stDone); end
    endtask

    task automatic test_or_and();
        logic [3:0] seq [5] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
        configure(4'b0110, 4'b0110, 4'b0000, 1'b1, 8'd1, 16'd1, 16'd2);
        din = 4'b0000;
        pulseArm();
        for (int s = 0; s < 5; s++) begin
            din = seq[s];
            tick();
        end
        nCompared++; if (stTrig !== 1'b1 || trigAddr !== 16'd2)
            begin nMismatched++; $display("[TB] FAIL or_trigger got trig=%b addr=%0d want 1 2", stTrig, trigAddr); end
        tick();
        nCompared++; if (stDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL or_done got %b want 1", stDone); end

        configure(4'b0110, 4'b0110, 4'b0000, 1'b0, 8'd1, 16'd1, 16'd2);
        pulseArm();
        for (int s = 0; s < 8; s++) begin
            din = s[0] ? 4'b0100 : 4'b0000;
            tick();
        end
        nCompared++; if (stTrig !== 1'b0 || stArmed !== 1'b1 || wtEn !== 1'b1)
            begin nMismatched++; $display("[TB] FAIL and_no_trigger got trig=%b armed=%b en=%b want 0 1 1", stTrig, stArmed, wtEn); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nCompared++; if (wtEn !== 1'b0 || stArmed !== 1'b0 || stDone !== 1'b0)
            begin nMismatched++; $display("[TB] FAIL abort_idle got en=%b armed=%b done=%b want 0 0 0", wtEn, stArmed, stDone); end
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        tick();
        nCompared++; if (wtEn !== 1'b0 || stArmed !== 1'b0)
            begin nMismatched++; $display("[TB] FAIL arm_abort_same got en=%b armed=%b want 0 0", wtEn, stArmed); end
    endtask

    task automatic test_abort_post();
        configure(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd2, 16'd0, 16'd5);
        din = 4'b0000;
        pulseArm();
        tick();
        tick();
        nCompared++; if (stTrig !== 1'b1 || trigAddr !== 16'd1)
            begin nMismatched++; $display("[TB] FAIL count2_trigger got trig=%b addr=%0d want 1 1", stTrig, trigAddr); end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        nCompared++; if (wtEn !== 1'b0 || stTrig !== 1'b1 || trigAddr !== 16'd1 || stDone !== 1'b0)
            begin nMismatched++; $display("[TB] FAIL abort_post_hold got en=%b trig=%b addr=%0d done=%b want 0 1 1 0", wtEn, stTrig, trigAddr, stDone); end
    endtask

    task automatic test_post_clamp();
        int nWrites = 0;
        configure(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd1, 16'd0, 16'd100);
        pulseArm();
        for (int s = 0; s <= 15; s++) begin
            din = 4'(s);
            tick();
            nWrites += int'(wtEn);
        end
        nCompared++; if (wtAddr !== 16'd15 || stDone !== 1'b0)
            begin nMismatched++; $display("[TB] FAIL clamp_last got addr=%0d done=%b want 15 0", wtAddr, stDone); end
        tick();
        nCompared++; if (stDone !== 1'b1 || wtEn !== 1'b0 || nWrites != 16)
            begin nMismatched++; $display("[TB] FAIL clamp_done got done=%b en=%b writes=%0d want 1 0 16", stDone, wtEn, nWrites); end
    endtask

    task automatic test_reset_mid_post();
        configure(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'd0, 16'd10);
        din = 4'b1111;
        pulseArm();
        tick(); tick(); tick();
        #2 rstN = 1'b0;
        #1;
        nCompared++; if (wtCe !== 1'b0 || wtEn !== 1'b0 || wtAddr !== 16'd0 || wtData !== 4'd0)
            begin nMismatched++; $display("[TB] FAIL async_reset_wt got ce=%b en=%b addr=%0d data=%h want 0", wtCe, wtEn, wtAddr, wtData); end
        nCompared++; if (stArmed !== 1'b0 || stTrig !== 1'b0 || stDone !== 1'b0 || trigAddr !== 16'd0)
            begin nMismatched++; $display("[TB] FAIL async_reset_st got %b%b%b addr=%0d want 000 0", stArmed, stTrig, stDone, trigAddr); end
        tick();
        rstN = 1'b1;
        tick();
        nCompared++; if (wtEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_idle got en=%b want 0", wtEn); end
        configure(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd1, 16'd3, 16'd0);
        pulseArm();
        tick();
        nCompared++; if (wtEn !== 1'b1 || wtAddr !== 16'd0)
            begin nMismatched++; $display("[TB] FAIL rearm_addr got en=%b addr=%0d want 1 0", wtEn, wtAddr); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

`ifdef CWC_STORAGE_QUAL_EN
    task automatic test_storage_qual();
        int expAddr = 0;
        logic expEn;
        configure(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'd1, 16'd1, 16'd1);
        sqEn = 1'b1; sqMask = 4'b1000;
        din = 4'b0000;
        pulseArm();
        for (int s = 0; s <= 11; s++) begin
            din = ((s % 4) == 3 ? 4'b1000 : 4'b0000) | (s == 10 ? 4'b0001 : 4'b0000);
            expEn = ((s % 4) == 3) || (s == 10);
            tick();
            nCompared++; if (wtEn !== expEn || wtCe !== 1'b1)
                begin nMismatched++; $display("[TB] FAIL sq_en s=%0d got en=%b ce=%b want %b 1", s, wtEn, wtCe, expEn); end
            if (expEn) begin
                nCompared++; if (wtAddr !== 16'(expAddr)) begin nMismatched++; $display("[TB] FAIL sq_addr got %0d want %0d", wtAddr, expAddr); end
                expAddr++;
            end
        end
        nCompared++; if (trigAddr !== 16'd2) begin nMismatched++; $display("[TB] FAIL sq_trig_addr got %0d want 2", trigAddr); end
        tick();
        nCompared++; if (stDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL sq_done got %b want 1", stDone); end
        sqEn = 1'b0;
    endtask
`endif

    initial begin
        rstN = 1'b0; arm = 1'b0; abort = 1'b0; din = '0;
        configure(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd1, 16'd0, 16'd0);
`ifdef CWC_STORAGE_QUAL_EN
        sqEn = 1'b0; sqMask = '0;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_edge();
        test_or_and();
        test_abort_post();
        test_post_clamp();
        test_reset_mid_post();
`ifdef CWC_STORAGE_QUAL_EN
        test_storage_qual();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
